// File: rtl/button_poll_master.sv
// button_poll_master
//
// Avalon-MM read master that polls a PIO input register at a fixed interval.
// It debounces the sampled bits across consecutive polls and publishes a
// filtered state plus single-cycle change events to local logic.
//
// Ports:
//   clk              system clock
//   reset_n          asynchronous active-low reset
//   enable           polling enable; when low, no new polls start
//   avm_address      read address, constant POLL_ADDR
//   avm_read         read request, held until the slave accepts it
//   avm_waitrequest  slave stall
//   avm_readdata     slave read data; only bits [DATA_W-1:0] are used
//   state_out        debounced input state
//   change_valid     one-cycle pulse when state_out changes
//   rise / fall      bits that went 0->1 / 1->0; zero outside change_valid
//   overrun          sticky flag: a poll tick arrived while one was pending
module button_poll_master #(
    parameter int unsigned       DATA_W       = 4,
    parameter int unsigned       ADDR_W       = 2,
    parameter int unsigned       POLL_ADDR    = 0,
    parameter int unsigned       POLL_DIV     = 50000,
    parameter int unsigned       READ_LATENCY = 1,
    parameter int unsigned       STABLE_POLLS = 3,
    parameter logic [DATA_W-1:0] RESET_STATE  = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] state_out,
    output logic              change_valid,
    output logic [DATA_W-1:0] rise,
    output logic [DATA_W-1:0] fall,
    output logic              overrun
);

    // POLL_DIV >= 4, so $clog2(POLL_DIV) bits always hold POLL_DIV-1.
    localparam int unsigned TIMER_W = $clog2(POLL_DIV);
    localparam int unsigned LAT_W   = 3;
    localparam int unsigned CNT_W   = 4;

    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_DIV - 1);
    localparam logic [LAT_W-1:0]   LAT_LOAD     = LAT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0]   STABLE_CNT   = CNT_W'(STABLE_POLLS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_EVAL = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;
    logic                avm_read_q, avm_read_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic [DATA_W-1:0]   cand_q, cand_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   state_out_q, state_out_d;
    logic                change_valid_q, change_valid_d;
    logic [DATA_W-1:0]   rise_q, rise_d;
    logic [DATA_W-1:0]   fall_q, fall_d;

    logic                tick_s;
    logic                leave_idle_s;
    logic [DATA_W-1:0]   cand_n_s;
    logic [CNT_W-1:0]    cnt_n_s;

    assign avm_address  = ADDR_W'(POLL_ADDR);
    assign avm_read     = avm_read_q;
    assign state_out    = state_out_q;
    assign change_valid = change_valid_q;
    assign rise         = rise_q;
    assign fall         = fall_q;
    assign overrun      = overrun_q;

    // Upper readdata bits carry nothing for this block.
    generate
        if (DATA_W < 32) begin : g_unused_rd
            logic unused_readdata_s;
            assign unused_readdata_s = ^avm_readdata[31:DATA_W];
        end
    endgenerate

    // Poll timer, tick-pending flag and sticky overrun.
    always_comb begin
        tick_s       = 1'b0;
        timer_d      = timer_q;
        pending_d    = pending_q;
        leave_idle_s = 1'b0;
        if (!enable) begin
            timer_d = TIMER_RELOAD;
        end else if (timer_q == '0) begin
            timer_d = TIMER_RELOAD;
            tick_s  = 1'b1;
        end else begin
            timer_d = timer_q - TIMER_W'(1);
        end
        // A tick in the IDLE cycle starts the read directly, so the pending
        // flag only holds ticks that arrive while a transaction is running.
        leave_idle_s = (state_q == ST_IDLE) && enable && (pending_q || tick_s);
        if (!enable) begin
            pending_d = 1'b0;
        end else if (leave_idle_s) begin
            pending_d = 1'b0;
        end else if (tick_s) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
        overrun_d = overrun_q | (tick_s & pending_q);
    end

    // Transaction FSM, read capture and debounce update.
    always_comb begin
        state_d        = state_q;
        avm_read_d     = avm_read_q;
        lat_d          = lat_q;
        sample_d       = sample_q;
        cand_d         = cand_q;
        cnt_d          = cnt_q;
        state_out_d    = state_out_q;
        change_valid_d = 1'b0;
        rise_d         = '0;
        fall_d         = '0;
        cand_n_s       = cand_q;
        cnt_n_s        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                avm_read_d = 1'b0;
                if (leave_idle_s) begin
                    state_d    = ST_REQ;
                    avm_read_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!avm_waitrequest) begin
                    // Acceptance cycle A; data is valid READ_LATENCY cycles later.
                    state_d    = ST_WAIT;
                    avm_read_d = 1'b0;
                    lat_d      = LAT_LOAD;
                end else begin
                    avm_read_d = 1'b1;
                end
            end
            ST_WAIT: begin
                avm_read_d = 1'b0;
                // lat_q holds READ_LATENCY in A+1, so 1 marks cycle A+READ_LATENCY.
                if (lat_q == LAT_W'(1)) begin
                    sample_d = avm_readdata[DATA_W-1:0];
                    state_d  = ST_EVAL;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_EVAL: begin
                avm_read_d = 1'b0;
                if (sample_q == cand_q) begin
                    cand_n_s = cand_q;
                    cnt_n_s  = (cnt_q >= STABLE_CNT) ? STABLE_CNT : (cnt_q + CNT_W'(1));
                end else begin
                    cand_n_s = sample_q;
                    cnt_n_s  = CNT_W'(1);
                end
                cand_d = cand_n_s;
                cnt_d  = cnt_n_s;
                if ((cnt_n_s == STABLE_CNT) && (cand_n_s != state_out_q)) begin
                    state_out_d    = cand_n_s;
                    change_valid_d = 1'b1;
                    rise_d         = cand_n_s & ~state_out_q;
                    fall_d         = ~cand_n_s & state_out_q;
                end else begin
                    state_out_d = state_out_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                avm_read_d = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            timer_q        <= TIMER_RELOAD;
            pending_q      <= 1'b0;
            overrun_q      <= 1'b0;
            avm_read_q     <= 1'b0;
            lat_q          <= '0;
            sample_q       <= RESET_STATE;
            cand_q         <= RESET_STATE;
            cnt_q          <= '0;
            state_out_q    <= RESET_STATE;
            change_valid_q <= 1'b0;
            rise_q         <= '0;
            fall_q         <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            pending_q      <= pending_d;
            overrun_q      <= overrun_d;
            avm_read_q     <= avm_read_d;
            lat_q          <= lat_d;
            sample_q       <= sample_d;
            cand_q         <= cand_d;
            cnt_q          <= cnt_d;
            state_out_q    <= state_out_d;
            change_valid_q <= change_valid_d;
            rise_q         <= rise_d;
            fall_q         <= fall_d;
        end
    end

endmodule

// File: tb/tb_button_poll_master.sv
// Testbench for button_poll_master: two instances with different latency,
// debounce depth and reset state share one stimulus stream; each is checked
// every cycle against a timestamp/history based model of the poller.
module tb_button_poll_master;

    localparam int DW = 4;
    localparam int AW = 2;
    localparam int PD = 8;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b0;
    logic        wr      = 1'b0;
    logic [31:0] rd      = 32'd0;

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [AW-1:0] addr_w [2];
    logic          read_w [2];
    logic [DW-1:0] st_w   [2];
    logic [DW-1:0] rise_w [2];
    logic [DW-1:0] fall_w [2];
    logic          cv_w   [2];
    logic          ovr_w  [2];

    task automatic chk(input string name, input int cfg, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s cfg%0d t=%0t got %0h want %0h", name, cfg, $time, got, want);
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int            L  = (g == 0) ? 1 : 3;
        localparam int            SP = (g == 0) ? 3 : 1;
        localparam int            PA = (g == 0) ? 0 : 2;
        localparam logic [DW-1:0] RS = (g == 0) ? 4'h0 : 4'hA;

        button_poll_master #(
            .DATA_W(DW), .ADDR_W(AW), .POLL_ADDR(PA), .POLL_DIV(PD),
            .READ_LATENCY(L), .STABLE_POLLS(SP), .RESET_STATE(RS)
        ) dut (
            .clk(clk), .reset_n(reset_n), .enable(enable),
            .avm_address(addr_w[g]), .avm_read(read_w[g]),
            .avm_waitrequest(wr), .avm_readdata(rd),
            .state_out(st_w[g]), .change_valid(cv_w[g]),
            .rise(rise_w[g]), .fall(fall_w[g]), .overrun(ovr_w[g])
        );

        // Model: ticks from a count of enabled cycles, transaction phases from
        // the acceptance timestamp, debounce from the last SP samples.
        logic [DW-1:0] hist [$];
        logic          e_read = 1'b0, e_cv = 1'b0, e_ovr = 1'b0;
        logic [DW-1:0] e_st = RS, e_rise = '0, e_fall = '0, samp = '0;
        int            cyc = 0, en_cnt = 0, acc = -100;
        bit            busy = 1'b0, pend = 1'b0, tick, all_eq;

        initial forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                cyc = 0; en_cnt = 0; acc = -100; busy = 1'b0; pend = 1'b0;
                hist.delete();
                e_read = 1'b0; e_cv = 1'b0; e_ovr = 1'b0;
                e_st = RS; e_rise = '0; e_fall = '0;
            end else begin
                tick   = enable && ((en_cnt % PD) == PD - 1);
                en_cnt = enable ? en_cnt + 1 : 0;
                e_cv = 1'b0; e_rise = '0; e_fall = '0;
                if (tick && pend) e_ovr = 1'b1;
                if (!busy) begin
                    if (enable && (pend || tick)) begin
                        busy = 1'b1; e_read = 1'b1; pend = 1'b0; acc = -100;
                    end
                end else begin
                    if (tick) pend = 1'b1;
                    if (e_read) begin
                        if (!wr) begin e_read = 1'b0; acc = cyc; end
                    end else if (cyc == acc + L) begin
                        samp = rd[DW-1:0];
                    end else if (cyc == acc + L + 1) begin
                        hist.push_back(samp);
                        if (hist.size() > SP) void'(hist.pop_front());
                        all_eq = (hist.size() == SP);
                        foreach (hist[k]) if (hist[k] != samp) all_eq = 1'b0;
                        if (all_eq && samp != e_st) begin
                            e_cv = 1'b1; e_rise = samp & ~e_st; e_fall = ~samp & e_st; e_st = samp;
                        end
                        busy = 1'b0;
                    end
                end
                if (!enable) pend = 1'b0;
                cyc++;
            end
        end

        // Per-cycle comparison, away from the active edge.
        initial forever begin
            @(negedge clk); #1;
            chk("addr",  g, 32'(addr_w[g]), 32'(PA));
            chk("read",  g, 32'(read_w[g]), 32'(e_read));
            chk("state", g, 32'(st_w[g]),   32'(e_st));
            chk("cv",    g, 32'(cv_w[g]),   32'(e_cv));
            chk("rise",  g, 32'(rise_w[g]), 32'(e_rise));
            chk("fall",  g, 32'(fall_w[g]), 32'(e_fall));
            chk("ovr",   g, 32'(ovr_w[g]),  32'(e_ovr));
        end
    end

    // Event log for cfg0 used by the hand-computed checks.
    int            cv0_cnt = 0;
    logic [DW-1:0] last_rise = '0, last_fall = '0;
    initial forever begin
        @(negedge clk); #1;
        if (cv_w[0]) begin cv0_cnt++; last_rise = rise_w[0]; last_fall = fall_w[0]; end
    end

    task automatic wait_read();
        int k;
        k = 0;
        while (!read_w[0] && k < 64) begin @(negedge clk); k++; end
        if (!read_w[0]) chk("read_timeout", 0, 32'd0, 32'd1);
    endtask

    // Wait for a poll, then past its capture so the next input change is clean.
    task automatic align();
        wait_read();
        repeat (4) @(negedge clk);
    endtask

    task automatic set_lo(input logic [DW-1:0] lo);
        logic [31:0] r;
        r  = $urandom();
        rd = {r[31:DW], lo};
    endtask

    initial begin
        int          n;
        int          snap;
        logic [31:0] r;
        logic [DW-1:0] lo;

        repeat (3) @(negedge clk);
        chk("rst_read",  0, 32'(read_w[0]), 32'd0);
        chk("rst_state", 0, 32'(st_w[0]),   32'd0);
        chk("rst_state", 1, 32'(st_w[1]),   32'hA);
        chk("rst_ovr",   0, 32'(ovr_w[0]),  32'd0);

        // Idle polling: one read every 8 cycles, first at the 8th cycle.
        reset_n = 1'b1; enable = 1'b1;
        n = 0; snap = cv0_cnt;
        repeat (36) begin @(negedge clk); if (read_w[0]) n++; end
        chk("idle_reads", 0, 32'(n), 32'd4);
        chk("idle_cv",    0, 32'(cv0_cnt - snap), 32'd0);
        chk("idle_addr",  0, 32'(addr_w[0]), 32'd0);

        // Step 0x0 -> 0x5, then 0x5 -> 0x4.
        align(); snap = cv0_cnt; set_lo(4'h5);
        repeat (32) begin @(negedge clk); set_lo(4'h5); end
        chk("step5_events", 0, 32'(cv0_cnt - snap), 32'd1);
        chk("step5_state",  0, 32'(st_w[0]),  32'h5);
        chk("step5_rise",   0, 32'(last_rise), 32'h5);
        chk("step5_fall",   0, 32'(last_fall), 32'h0);
        align(); snap = cv0_cnt; set_lo(4'h4);
        repeat (32) @(negedge clk);
        chk("step4_events", 0, 32'(cv0_cnt - snap), 32'd1);
        chk("step4_rise",   0, 32'(last_rise), 32'h0);
        chk("step4_fall",   0, 32'(last_fall), 32'h1);

        // Glitch lasting two polls: no event.
        align(); snap = cv0_cnt; set_lo(4'h3);
        align(); align(); set_lo(4'h4);
        repeat (32) @(negedge clk);
        chk("glitch_events", 0, 32'(cv0_cnt - snap), 32'd0);
        chk("glitch_state",  0, 32'(st_w[0]), 32'h4);

        // Waitrequest held 20 cycles: read stays high, overrun sets.
        align(); wr = 1'b1; n = 0;
        repeat (20) begin @(negedge clk); if (read_w[0]) n++; end
        chk("stall_read_cycles", 0, 32'(n), 32'd17);
        chk("stall_ovr",         0, 32'(ovr_w[0]), 32'd1);
        wr = 1'b0;
        @(negedge clk);
        chk("stall_released", 0, 32'(read_w[0]), 32'd0);

        // Reset while a read is waiting for acceptance.
        repeat (8) @(negedge clk);
        wr = 1'b1;
        wait_read();
        reset_n = 1'b0;
        #1;
        chk("rst_req_read",  0, 32'(read_w[0]), 32'd0);
        chk("rst_req_state", 1, 32'(st_w[1]),   32'hA);
        chk("rst_req_ovr",   0, 32'(ovr_w[0]),  32'd0);
        @(negedge clk);
        reset_n = 1'b1; wr = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!read_w[0] && n < 32);
        chk("resume_delay", 0, 32'(n), 32'(PD));

        // Disabled: no reads.
        align(); enable = 1'b0; n = 0;
        repeat (40) begin @(negedge clk); if (read_w[0]) n++; end
        chk("disabled_reads", 0, 32'(n), 32'd0);
        enable = 1'b1;

        // Randomized phase: slow and fast-changing inputs, stalls, enable drops, resets.
        lo = '0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            r = $urandom();
            if ((i % 1000) < 500) begin
                if ($urandom_range(0, 39) == 0) lo = DW'($urandom_range(0, 15));
            end else begin
                lo = DW'($urandom_range(0, 15));
            end
            rd      = {r[31:DW], lo};
            wr      = ($urandom_range(0, 3) == 0);
            enable  = ($urandom_range(0, 49) != 0);
            reset_n = ($urandom_range(0, 999) != 0);
        end
        @(negedge clk);
        reset_n = 1'b1; wr = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/button_poll_master.md
# button_poll_master

Avalon-MM read master that periodically polls a PIO input slave (button/switch port, 32-bit readdata, input bits in the LSBs), debounces the sampled bits across consecutive polls and reports stable state plus one-cycle change events to local logic. Sits beside the PIO slave on the same clock domain. Gives hardware-only consumers a filtered button state without CPU involvement.

## Interface

Parameters:
- DATA_W, 4, number of PIO input bits used (readdata[DATA_W-1:0])
- ADDR_W, 2, width of avm_address
- POLL_ADDR, 0, slave register address polled (data register)
- POLL_DIV, 50000, clock cycles between poll ticks (>=4)
- READ_LATENCY, 1, fixed cycles from read acceptance to valid readdata (1..4)
- STABLE_POLLS, 3, consecutive identical samples required to accept a new state (1..15)
- RESET_STATE, 0, reset value of state_out

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset; clock clk
- enable  in  1  polling enable
- avm_address  out  ADDR_W  always POLL_ADDR
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall; tie 0 for PIO slaves without waitrequest
- avm_readdata  in  32  slave read data
- state_out  out  DATA_W  debounced input state
- change_valid  out  1  one-cycle pulse when state_out changes
- rise  out  DATA_W  bits that went 0->1 (valid with change_valid, else 0)
- fall  out  DATA_W  bits that went 1->0 (valid with change_valid, else 0)
- overrun  out  1  sticky: poll tick dropped while one already pending

## Operation

- Poll timer: counter loads POLL_DIV-1, decrements each cycle while enable=1; at 0 generates tick and reloads. enable=0: counter held at POLL_DIV-1, pending tick cleared; in-flight transaction still completes.
- Tick pending flag: set on tick, cleared when FSM leaves IDLE. Tick while flag already set -> overrun<=1 (sticky until reset).
- FSM states:
  - IDLE: avm_read=0. Pending tick -> REQ.
  - REQ: avm_read=1. Stay while avm_waitrequest=1. Cycle with waitrequest=0 = acceptance -> WAIT, latency counter = READ_LATENCY.
  - WAIT: avm_read=0; decrement; in cycle where counter reaches READ_LATENCY cycles after acceptance, capture avm_readdata[DATA_W-1:0] into sample -> EVAL.
  - EVAL: one cycle debounce update -> IDLE.
- Debounce (in EVAL): sample==candidate -> count=min(count+1, STABLE_POLLS); else candidate<=sample, count<=1. When resulting count==STABLE_POLLS and candidate!=state_out: state_out<=candidate, change_valid<=1, rise<=candidate&~state_out, fall<=~candidate&state_out.
- change_valid/rise/fall are registered pulses, exactly one cycle; zero otherwise.
- avm_readdata[31:DATA_W] ignored. avm_address constant.
- Reset values: avm_read=0, state_out=RESET_STATE, change_valid=0, rise=0, fall=0, overrun=0, candidate=RESET_STATE, count=0, timer=POLL_DIV-1, FSM=IDLE.

## Timing

- avm_read registered: tick in cycle T -> avm_read high from T+1.
- Acceptance cycle A (avm_read=1, waitrequest=0); avm_read low from A+1.
- readdata sampled in cycle A+READ_LATENCY; state_out/change_valid visible in cycle A+READ_LATENCY+2.
- waitrequest=0, READ_LATENCY=1: tick T -> read T+1 -> sample T+2 -> EVAL T+3 -> outputs T+4. One transaction occupies 4 cycles; POLL_DIV>=4 guarantees no overrun with zero waitrequest.
- Reset mid-transaction: avm_read drops asynchronously, transaction abandoned; late readdata ignored.
- Input change then reversal within fewer than STABLE_POLLS polls: no event, state_out unchanged.
- STABLE_POLLS=1: every differing sample produces an event on next EVAL.

## Test plan

- Reset, enable=1, POLL_DIV=8, readdata=0: avm_read pulses once every 8 cycles at address 0, no change_valid, overrun=0.
- readdata steps 0x0->0x5, STABLE_POLLS=3: change_valid exactly once after 3rd poll seeing 0x5, state_out=0x5, rise=0x5, fall=0x0; then 0x5->0x4 gives fall=0x1, rise=0.
- Glitch: readdata 0x0->0x3 for 2 polls then back 0x0: no change_valid, state_out=0x0.
- avm_waitrequest held high 20 cycles with POLL_DIV=8: avm_read stays high until waitrequest=0, single acceptance, overrun=1, still one read per acceptance.
- READ_LATENCY=3, readdata changed only in cycle A+3: that value captured, value present in A+1/A+2 ignored.
- Assert reset_n low during REQ: avm_read=0 immediately, state_out=RESET_STATE; polling resumes POLL_DIV cycles after release; enable=0 stops all reads.
